exp_lut_arbiter: RTL
====================

// Module: exp_lut_arbiter
// PURPOSE
//   Shares one registered 16-entry exp/softmax lookup ROM (4-bit address, 16-bit result,
//   1-cycle read latency, no stall input) between NUM_REQ requesters.
//   - Round-robin arbitration drives the ROM address and tags each read with its requester ID.
//   - Returns each result through a 2-entry response FIFO with a valid/ready handshake.
//   - Sits between the softmax lane engines and the single shared LUT instance.
// PARAMETERS
//   NUM_REQ  4   number of requesters, 2..8
//   IDX_W    4   ROM address width; fixed by the ROM depth
//   DATA_W   16  ROM result width
//   ID_W     2   requester-ID width, $clog2(NUM_REQ)
// PORTS
//   clk        in   1               system clock, rising edge
//   rst_n      in   1               asynchronous active-low reset
//   req_valid  in   NUM_REQ         per-requester lookup request
//   req_idx    in   NUM_REQ*IDX_W   packed indices; requester k uses bits [k*IDX_W +: IDX_W]
//   req_ready  out  NUM_REQ         one-hot accept; at most one bit high per cycle
//   rom_addr   out  IDX_W           to ROM address input (ROM registers it on the same clk)
//   rom_data   in   DATA_W          from ROM registered output; valid 1 cycle after the address
//   rsp_valid  out  1               response available at the FIFO head
//   rsp_id     out  ID_W            requester that issued the head response
//   rsp_data   out  DATA_W          ROM result for the head response
//   rsp_ready  in   1               consumer accepts the head response
//   busy       out  1               any request in flight or any FIFO entry occupied
// BEHAVIOUR
//   - Reset values (async): req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0,
//     inflight=0, FIFO empty, rr pointer=NUM_REQ-1 (requester 0 wins first).
//   - Issue condition, combinational: issue = |req_valid && (fifo_cnt + inflight - pop) < 2,
//     where pop = rsp_valid && rsp_ready. This guarantees ROM data always has a FIFO slot.
//   - Grant: search req_valid starting at ptr+1, wrapping modulo NUM_REQ.
//     The first set bit wins. req_ready[g] = issue.
//     rom_addr = req_idx of the winner when issuing, else 0 (combinational).
//   - Request handshake completes when req_valid[k] && req_ready[k]. The pointer updates to g
//     only on issue; no issue leaves the pointer unchanged.
//   - Cycle T issue: the ROM latches rom_addr at edge T. The block registers inflight=1 and id_q=g.
//     At edge T+1, {id_q, rom_data} is pushed into the FIFO. Request-to-rsp_valid latency is
//     2 cycles. Throughput is 1/cycle while rsp_ready stays high.
//   - FIFO: 2 entries, first-word fall-through. rsp_* show the head. Push and pop in the same
//     cycle are legal at any occupancy. Pointers wrap modulo 2.
//   - Full FIFO with rsp_ready low: issue is blocked and all req_ready stay 0. ROM output is
//     ignored, since inflight=0.
//   - Requesters may drop req_valid without a handshake. The arbiter is stateless for them.
//   - busy = inflight | (fifo_cnt != 0).
//   - Reset mid-operation: the in-flight read and FIFO contents are discarded. Nothing is
//     emitted after rst_n deasserts until a new issue occurs.
//   - Arithmetic: fifo_cnt is 2 bits (0..2). inflight is 1 bit. The credit sum is computed
//     in 3 bits, so there is no overflow.
// STRUCTURE
//   - Package softmax_lut_pkg: IDX_W, DATA_W, LUT_LATENCY=1, RSP_FIFO_DEPTH=2, and function
//     clog2.
//   - Sub-module rr_arbiter #(N): inputs req and advance, outputs one-hot gnt and binary
//     gnt_id; it holds the pointer.
//   - The response FIFO is written inline; it is too small to warrant its own module.
// TESTING
//   1. Reset, then req_valid=4'b0001, idx0=4'h5, ROM RESULT_05=16'h1234, rsp_ready=1
//      -> req_ready[0] at T0; rsp_valid=1, rsp_id=0, rsp_data=16'h1234 at T2.
//   2. All four requesters valid every cycle, rsp_ready=1
//      -> grants 0,1,2,3,0,... one per cycle; rsp_id follows the same order 2 cycles later.
//   3. rsp_ready=0 with requests pending -> exactly 2 issues, then req_ready=0, busy=1.
//      Set rsp_ready=1 -> both drain in order, issuing resumes the same cycle as the first pop.
//   4. req_valid=4'b1010 with ptr=1 -> requester 3 wins next, then 1.
//      Requester 2 asserted later is not starved: granted within NUM_REQ issues.
//   5. Assert rst_n=0 for 1 cycle with one read in flight and 1 FIFO entry
//      -> after release rsp_valid=0, busy=0, and the next grant goes to requester 0.
//   6. idx=4'hF on requester 2 -> rsp_data equals RESULT_15 and rsp_id=2
//      (checks the top address and packed-index slicing).

Source files
------------

// File: rtl/softmax_lut_pkg.sv
// Shared constants for the softmax exp-LUT sharing logic: ROM geometry, read latency,
// response buffering depth and a constant-foldable ceil(log2) helper.
package softmax_lut_pkg;

    localparam int IDX_W          = 4;
    localparam int DATA_W         = 16;
    localparam int LUT_LATENCY    = 1;
    localparam int RSP_FIFO_DEPTH = 2;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches req starting one past the last winner, wrapping modulo N.
// The pointer only moves to the winner when advance is asserted.
module rr_arbiter
    import softmax_lut_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id
);

    localparam logic [ID_W-1:0] PTR_RST = ID_W'(N - 1);

    logic [ID_W-1:0] ptr_reg;
    logic [ID_W-1:0] ptr_next;
    logic [ID_W-1:0] cand;
    logic            found;

    always_comb begin
        gnt_id = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= N; i++) begin
            cand = ID_W'((int'(ptr_reg) + i) % N);
            if (!found && req[cand]) begin
                found  = 1'b1;
                gnt_id = cand;
            end
        end
        gnt = found ? (N'(1) << gnt_id) : '0;
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (advance && found) begin
            ptr_next = gnt_id;
        end
    end

    // Reset pointer at N-1 so requester 0 is the first winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= PTR_RST;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/exp_lut_arbiter.sv
// Shares one registered exp/softmax ROM between NUM_REQ requesters: round-robin issue,
// tagged 1-cycle ROM read, and a 2-entry fall-through response FIFO with valid/ready.
module exp_lut_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = softmax_lut_pkg::IDX_W,
    parameter int DATA_W  = softmax_lut_pkg::DATA_W,
    parameter int ID_W    = softmax_lut_pkg::clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_idx,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [IDX_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]        rom_data,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [DATA_W-1:0]        rsp_data,
    input  logic                     rsp_ready,
    output logic                     busy
);

    import softmax_lut_pkg::*;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic [IDX_W-1:0]   idx_arr [NUM_REQ];
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;

    logic               issue;
    logic               push;
    logic               pop;
    logic [2:0]         credit;

    logic               inflight_reg;
    logic [ID_W-1:0]    id_reg;

    rsp_t               fifo_mem_reg [RSP_FIFO_DEPTH];
    logic               wr_ptr_reg;
    logic               rd_ptr_reg;
    logic [1:0]         cnt_reg;
    logic [1:0]         cnt_next;
    rsp_t               head;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign idx_arr[gi]   = req_idx[gi*IDX_W +: IDX_W];
            assign req_ready[gi] = issue & gnt[gi];
        end
    endgenerate

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (issue),
        .gnt     (gnt),
        .gnt_id  (gnt_id)
    );

    // Credit check counts the in-flight read so ROM data always lands in a free slot.
    assign pop    = rsp_valid & rsp_ready;
    assign push   = inflight_reg;
    assign credit = {1'b0, cnt_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign issue  = (|req_valid) && (credit < 3'(RSP_FIFO_DEPTH));

    assign rom_addr = issue ? idx_arr[gnt_id] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_reg <= 1'b0;
            id_reg       <= '0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                id_reg <= gnt_id;
            end
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        case ({push, pop})
            2'b10:   cnt_next = cnt_reg + 2'd1;
            2'b01:   cnt_next = cnt_reg - 2'd1;
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
                fifo_mem_reg[i] <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            cnt_reg    <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem_reg[wr_ptr_reg] <= '{id: id_reg, data: rom_data};
                wr_ptr_reg               <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            cnt_reg <= cnt_next;
        end
    end

    assign head      = fifo_mem_reg[rd_ptr_reg];
    assign rsp_valid = (cnt_reg != 2'd0);
    assign rsp_id    = head.id;
    assign rsp_data  = head.data;
    assign busy      = inflight_reg | (cnt_reg != 2'd0);

endmodule
